// File: rtl/lsu_mem_ctrl.sv
// Memory-stage load/store controller: turns rd_en/wr_en into a single
// data-memory bus transaction, stalls the pipeline while it is pending and
// returns sign/zero-extended load data to writeback.
module lsu_mem_ctrl #(
    parameter int unsigned ADDR_W  = 32,
    parameter int unsigned DATA_W  = 32,
    parameter int unsigned TIMEOUT = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rd_en,
    input  logic              wr_en,
    input  logic [2:0]        funct3,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    output logic              stall,
    output logic [DATA_W-1:0] load_data,
    output logic              access_err,
    output logic              bus_err,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic [3:0]        mem_be,
    input  logic              mem_gnt,
    input  logic              mem_rvalid,
    input  logic [DATA_W-1:0] mem_rdata
);

    localparam int unsigned CNT_W = $clog2(TIMEOUT) + 1;

    typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} state_t;

    state_t              state, state_d;
    logic [CNT_W-1:0]    cnt, cnt_d;
    logic [2:0]          f3_q, f3_d;
    logic [1:0]          lo_q, lo_d;
    logic                req_d, we_d, bus_err_d;
    logic [ADDR_W-1:0]   addr_d;
    logic [DATA_W-1:0]   wdata_d, ld_d;
    logic [3:0]          be_d;
    logic                req_any, illegal, legal_req, timed_out;
    logic [3:0]          st_be;
    logic [DATA_W-1:0]   st_wdata, ld_fmt, rd_shift;

    // Request legality: conflicting enables, unsupported funct3, misalignment
    always_comb begin
        req_any = rd_en | wr_en;
        illegal = 1'b0;
        if (rd_en && wr_en)
            illegal = 1'b1;
        else if (rd_en && !(funct3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101}))
            illegal = 1'b1;
        else if (wr_en && !(funct3 inside {3'b000, 3'b001, 3'b010}))
            illegal = 1'b1;
        else if (funct3[1:0] == 2'b01 && addr[0])
            illegal = 1'b1;
        else if (funct3[1:0] == 2'b10 && addr[1:0] != 2'b00)
            illegal = 1'b1;
        legal_req = (state == IDLE) && req_any && !illegal;
    end

    // Stall and access error are same-cycle responses to the request inputs
    assign stall      = rst && ((state == REQ) || (state == WAIT) || legal_req);
    assign access_err = rst && (state == IDLE) && req_any && illegal;

    // Store lane steering: byte enables and replicated write data
    always_comb begin
        case (funct3[1:0])
            2'b00:   begin st_be = 4'b0001 << addr[1:0];          st_wdata = {4{wdata[7:0]}};  end
            2'b01:   begin st_be = 4'b0011 << {addr[1], 1'b0};    st_wdata = {2{wdata[15:0]}}; end
            default: begin st_be = 4'b1111;                       st_wdata = wdata;            end
        endcase
    end

    // Load formatting from the latched size/sign and byte offset
    always_comb begin
        rd_shift = mem_rdata >> {lo_q, 3'b000};
        case (f3_q)
            3'b000:  ld_fmt = {{24{rd_shift[7]}}, rd_shift[7:0]};
            3'b001:  ld_fmt = {{16{rd_shift[15]}}, rd_shift[15:0]};
            3'b100:  ld_fmt = {24'h0, rd_shift[7:0]};
            3'b101:  ld_fmt = {16'h0, rd_shift[15:0]};
            default: ld_fmt = mem_rdata;
        endcase
    end

    assign timed_out = (cnt >= CNT_W'(TIMEOUT - 1));

    // Next-state and next-register values
    always_comb begin
        state_d   = state;
        cnt_d     = cnt;
        f3_d      = f3_q;
        lo_d      = lo_q;
        req_d     = mem_req;
        we_d      = mem_we;
        addr_d    = mem_addr;
        wdata_d   = mem_wdata;
        be_d      = mem_be;
        ld_d      = load_data;
        bus_err_d = 1'b0;
        case (state)
            IDLE: begin
                if (legal_req) begin
                    req_d   = 1'b1;
                    we_d    = wr_en;
                    addr_d  = {addr[ADDR_W-1:2], 2'b00};
                    be_d    = wr_en ? st_be : 4'b1111;
                    wdata_d = wr_en ? st_wdata : '0;
                    f3_d    = funct3;
                    lo_d    = addr[1:0];
                    cnt_d   = '0;
                    state_d = REQ;
                end
            end
            REQ: begin
                cnt_d = cnt + CNT_W'(1);
                if (mem_gnt && (mem_we || mem_rvalid)) begin
                    req_d = 1'b0;
                    if (!mem_we)
                        ld_d = ld_fmt;
                    state_d = DONE;
                end else if (timed_out) begin
                    req_d     = 1'b0;
                    bus_err_d = 1'b1;
                    if (!mem_we)
                        ld_d = '0;
                    state_d = DONE;
                end else if (mem_gnt) begin
                    req_d   = 1'b0;
                    state_d = WAIT;
                end
            end
            WAIT: begin
                cnt_d = cnt + CNT_W'(1);
                if (mem_rvalid) begin
                    ld_d    = ld_fmt;
                    state_d = DONE;
                end else if (timed_out) begin
                    bus_err_d = 1'b1;
                    ld_d      = '0;
                    state_d   = DONE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and output registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            cnt       <= '0;
            f3_q      <= '0;
            lo_q      <= '0;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            mem_be    <= '0;
            load_data <= '0;
            bus_err   <= 1'b0;
        end else begin
            state     <= state_d;
            cnt       <= cnt_d;
            f3_q      <= f3_d;
            lo_q      <= lo_d;
            mem_req   <= req_d;
            mem_we    <= we_d;
            mem_addr  <= addr_d;
            mem_wdata <= wdata_d;
            mem_be    <= be_d;
            load_data <= ld_d;
            bus_err   <= bus_err_d;
        end
    end

endmodule

// File: tb/tb_lsu_mem_ctrl.sv
// Randomized self-checking bench for lsu_mem_ctrl against a transaction-level model.
module tb_lsu_mem_ctrl;

    localparam int unsigned TO = 16;

    logic        clk = 1'b0;
    logic        rst;
    logic        rd_en, wr_en;
    logic [2:0]  funct3;
    logic [31:0] addr, wdata;
    logic        stall, access_err, bus_err;
    logic [31:0] load_data;
    logic        mem_req, mem_we;
    logic [31:0] mem_addr, mem_wdata;
    logic [3:0]  mem_be;
    logic        mem_gnt, mem_rvalid;
    logic [31:0] mem_rdata;

    lsu_mem_ctrl #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst), .rd_en(rd_en), .wr_en(wr_en), .funct3(funct3),
        .addr(addr), .wdata(wdata), .stall(stall), .load_data(load_data),
        .access_err(access_err), .bus_err(bus_err), .mem_req(mem_req),
        .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_be(mem_be), .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid),
        .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Model state: expected bus fields of the current access and held load result
    logic [31:0] e_addr, e_wdata, m_load;
    logic [3:0]  e_be;
    logic        e_we;
    bit          in_txn = 1'b0;
    bit          cmp_en = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int nbytes(input logic [2:0] f3);
        return 1 << f3[1:0];
    endfunction

    function automatic bit is_legal(input bit rd, input bit wr, input logic [2:0] f3, input logic [31:0] a);
        bit ok;
        if (rd && wr) return 1'b0;
        if (rd) ok = f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5};
        else    ok = f3 inside {3'd0, 3'd1, 3'd2};
        if (!ok) return 1'b0;
        return (a % nbytes(f3)) == 0;
    endfunction

    function automatic logic [3:0] model_be(input logic [2:0] f3, input logic [31:0] a);
        logic [3:0] b = '0;
        int off = int'(a % 4);
        for (int i = 0; i < 4; i++)
            if (i >= off && i < off + nbytes(f3)) b[i] = 1'b1;
        return b;
    endfunction

    function automatic logic [31:0] model_wd(input logic [2:0] f3, input logic [31:0] wd);
        logic [31:0] r;
        for (int i = 0; i < 4; i++)
            r[8*i +: 8] = wd[8*(i % nbytes(f3)) +: 8];
        return r;
    endfunction

    function automatic logic [31:0] model_ld(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] rd);
        int n = nbytes(f3);
        logic [63:0] mask = (64'd1 << (8 * n)) - 64'd1;
        logic [63:0] v = (64'(rd) >> (8 * (a % 4))) & mask;
        if (!f3[2] && n < 4 && v[8*n-1]) v = v | ~mask;
        return v[31:0];
    endfunction

    // Every-cycle compare: held load result, stable bus fields while requesting
    always @(negedge clk) begin
        if (cmp_en) begin
            chk("load_data_hold", load_data, m_load);
            if (mem_req) begin
                chk("mem_addr", mem_addr, e_addr);
                chk("mem_we", 32'(mem_we), 32'(e_we));
                chk("mem_be", 32'(mem_be), 32'(e_be));
                chk("mem_wdata", mem_wdata, e_wdata);
            end
            if (!in_txn) chk("idle_mem_req", 32'(mem_req), 32'd0);
        end
    end

    // One complete access: gd = REQ cycles before gnt, rv = cycles from gnt to rvalid
    task automatic txn(input bit rd, input bit wr, input logic [2:0] f3, input logic [31:0] a,
                       input logic [31:0] wd, input int gd, input int rv, input logic [31:0] rdat,
                       output logic [3:0] seen_be, output logic [31:0] seen_wd,
                       output logic [31:0] seen_addr);
        bit legal, tmo;
        int total, busy;
        seen_be = '0; seen_wd = '0; seen_addr = '0;
        legal = is_legal(rd, wr, f3, a);
        @(posedge clk); #1;
        rd_en = rd; wr_en = wr; funct3 = f3; addr = a; wdata = wd;
        mem_gnt = 1'b0; mem_rvalid = 1'b0;
        e_we = wr; e_addr = a & ~32'd3;
        e_be = wr ? model_be(f3, a) : 4'hF;
        e_wdata = wr ? model_wd(f3, wd) : 32'd0;
        in_txn = 1'b1;
        @(negedge clk);
        chk("idle_stall", 32'(stall), 32'(legal));
        chk("idle_access_err", 32'(access_err), 32'(!legal));
        chk("idle_mem_req", 32'(mem_req), 32'd0);
        if (!legal) begin
            @(posedge clk); #1;
            rd_en = 1'b0; wr_en = 1'b0;
            @(negedge clk);
            chk("after_err_mem_req", 32'(mem_req), 32'd0);
            chk("after_err_stall", 32'(stall), 32'd0);
            in_txn = 1'b0;
            return;
        end
        total = gd + 1 + (rd ? rv : 0);
        tmo   = total > TO;
        busy  = tmo ? TO : total;
        for (int k = 0; k < busy; k++) begin
            @(posedge clk); #1;
            mem_gnt    = (k == gd) || (rd && k > gd && $urandom_range(0, 3) == 0);
            mem_rvalid = rd && (k == gd + rv);
            mem_rdata  = mem_rvalid ? rdat : $urandom;
            @(negedge clk);
            chk("busy_stall", 32'(stall), 32'd1);
            chk("busy_mem_req", 32'(mem_req), 32'(k <= gd));
            chk("busy_bus_err", 32'(bus_err), 32'd0);
            chk("busy_access_err", 32'(access_err), 32'd0);
            if (mem_req) begin seen_be = mem_be; seen_wd = mem_wdata; seen_addr = mem_addr; end
        end
        @(posedge clk); #1;
        mem_gnt    = 1'($urandom_range(0, 1));
        mem_rvalid = 1'($urandom_range(0, 1));
        mem_rdata  = $urandom;
        if (rd) m_load = tmo ? 32'd0 : model_ld(f3, a, rdat);
        @(negedge clk);
        chk("done_stall", 32'(stall), 32'd0);
        chk("done_mem_req", 32'(mem_req), 32'd0);
        chk("done_bus_err", 32'(bus_err), 32'(tmo));
        chk("done_access_err", 32'(access_err), 32'd0);
        @(posedge clk); #1;
        rd_en = 1'b0; wr_en = 1'b0; mem_gnt = 1'b0; mem_rvalid = 1'b0;
        in_txn = 1'b0;
    endtask

    logic [3:0]  s_be;
    logic [31:0] s_wd, s_addr;

    initial begin
        rst = 1'b0; rd_en = 1'b0; wr_en = 1'b0; funct3 = '0; addr = '0; wdata = '0;
        mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0;
        m_load = '0; e_addr = '0; e_wdata = '0; e_be = '0; e_we = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_stall", 32'(stall), 32'd0);
        chk("rst_load_data", load_data, 32'd0);
        chk("rst_errs", 32'({access_err, bus_err}), 32'd0);
        chk("rst_mem_req_we", 32'({mem_req, mem_we}), 32'd0);
        chk("rst_mem_addr", mem_addr, 32'd0);
        chk("rst_mem_wdata", mem_wdata, 32'd0);
        chk("rst_mem_be", 32'(mem_be), 32'd0);
        @(posedge clk); #1;
        rst = 1'b1;
        cmp_en = 1'b1;

        // Directed cases with hand-computed literals
        txn(0, 1, 3'b010, 32'h104, 32'hDEADBEEF, 0, 0, 32'h0, s_be, s_wd, s_addr);
        chk("sw_addr", s_addr, 32'h104);
        chk("sw_be", 32'(s_be), 32'hF);
        chk("sw_wdata", s_wd, 32'hDEADBEEF);
        txn(0, 1, 3'b001, 32'h2, 32'h1234ABCD, 1, 0, 32'h0, s_be, s_wd, s_addr);
        chk("sh_be", 32'(s_be), 32'hC);
        chk("sh_wdata", s_wd, 32'hABCDABCD);
        txn(1, 0, 3'b101, 32'h2, 32'h0, 0, 1, 32'hABCD0000, s_be, s_wd, s_addr);
        chk("lhu_data", load_data, 32'h0000ABCD);
        txn(1, 0, 3'b010, 32'h101, 32'h0, 0, 0, 32'h0, s_be, s_wd, s_addr);
        txn(1, 1, 3'b010, 32'h100, 32'h0, 0, 0, 32'h0, s_be, s_wd, s_addr);
        txn(1, 0, 3'b011, 32'h100, 32'h0, 0, 0, 32'h0, s_be, s_wd, s_addr);
        chk("err_keeps_load", load_data, 32'h0000ABCD);
        txn(1, 0, 3'b010, 32'h40, 32'h0, 100, 0, 32'h0, s_be, s_wd, s_addr);
        chk("timeout_load_zero", load_data, 32'h0);

        // Randomized accesses with idle gaps carrying stray bus strobes
        for (int t = 0; t < 80; t++) begin
            int sel, gd, rv;
            bit rd, wr;
            logic [2:0]  f3;
            logic [31:0] a;
            sel = $urandom_range(0, 9);
            rd  = (sel <= 5);
            wr  = (sel == 0) || (sel >= 6);
            f3  = 3'($urandom_range(0, 7));
            if ($urandom_range(0, 9) < 7)
                f3 = wr ? 3'($urandom_range(0, 2)) : ($urandom_range(0, 1) ? 3'($urandom_range(0, 2)) : 3'($urandom_range(4, 5)));
            a = $urandom;
            if ($urandom_range(0, 3) != 0) a = a & ~((32'd1 << f3[1:0]) - 32'd1);
            gd = ($urandom_range(0, 9) == 0) ? 20 : $urandom_range(0, 4);
            rv = ($urandom_range(0, 9) == 0) ? 15 : $urandom_range(0, 4);
            txn(rd, wr, f3, a, $urandom, gd, rv, $urandom, s_be, s_wd, s_addr);
            if ($urandom_range(0, 2) == 0) begin
                mem_gnt = 1'($urandom_range(0, 1)); mem_rvalid = 1'($urandom_range(0, 1));
                @(negedge clk);
                chk("gap_stall", 32'(stall), 32'd0);
                chk("gap_access_err", 32'(access_err), 32'd0);
                @(posedge clk); #1;
                mem_gnt = 1'b0; mem_rvalid = 1'b0;
            end
        end

        // LB sign extension, then reset abandoning a load in WAIT
        txn(1, 0, 3'b000, 32'h203, 32'h0, 0, 3, 32'h80123456, s_be, s_wd, s_addr);
        chk("lb_sext", load_data, 32'hFFFFFF80);
        @(posedge clk); #1;
        rd_en = 1'b1; wr_en = 1'b0; funct3 = 3'b010; addr = 32'h10;
        e_we = 1'b0; e_addr = 32'h10; e_be = 4'hF; e_wdata = 32'h0; in_txn = 1'b1;
        @(posedge clk); #1; mem_gnt = 1'b1;
        @(posedge clk); #1; mem_gnt = 1'b0;
        @(negedge clk);
        chk("wait_stall", 32'(stall), 32'd1);
        @(posedge clk); #2;
        rst = 1'b0; m_load = 32'h0;
        #1;
        chk("rst_async_stall", 32'(stall), 32'd0);
        chk("rst_async_mem_req", 32'(mem_req), 32'd0);
        chk("rst_async_load", load_data, 32'd0);
        rd_en = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1; in_txn = 1'b0;
        txn(1, 0, 3'b010, 32'h0, 32'h0, 1, 2, 32'hCAFEF00D, s_be, s_wd, s_addr);
        chk("post_rst_lw", load_data, 32'hCAFEF00D);

        repeat (2) @(posedge clk);
        cmp_en = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/lsu_mem_ctrl.md
Name: lsu_mem_ctrl

Overview:
- Memory-stage load/store controller. It consumes the `rd_en` and `wr_en` memory-stage control signals and carries out the data-memory bus transaction.
- It drives `stall`, which the pipeline ANDs-inverted into the control/data buffer enables, so the M/W registers hold while a transaction is pending.
- It returns the formatted load data to the writeback mux.
- It sits between the memory-stage pipeline registers and the data-memory bus.

Parameters:
- ADDR_W, 32, byte address width.
- DATA_W, 32, bus data width (fixed at 32 for byte-lane logic).
- TIMEOUT, 16, maximum cycles spent in REQ+WAIT before the access is aborted with `bus_err`.

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous, active-low reset
- rd_en  in  1  load request from the memory stage
- wr_en  in  1  store request from the memory stage
- funct3  in  3  access size/sign (RISC-V load/store funct3)
- addr  in  ADDR_W  effective byte address
- wdata  in  DATA_W  store data (unaligned to lane)
- stall  out  1  hold pipeline (disable M/W buffers)
- load_data  out  DATA_W  sign/zero-extended load result
- access_err  out  1  one-cycle pulse: misaligned, illegal funct3, or rd_en&wr_en
- bus_err  out  1  one-cycle pulse: transaction timed out
- mem_req  out  1  bus request
- mem_we  out  1  bus write enable
- mem_addr  out  ADDR_W  word-aligned bus address (addr[1:0]=0)
- mem_wdata  out  DATA_W  lane-replicated store data
- mem_be  out  4  byte enables
- mem_gnt  in  1  bus accepts request this cycle
- mem_rvalid  in  1  read data valid
- mem_rdata  in  DATA_W  read data

Behaviour:
- **Reset** (rst=0, async): state=IDLE, timeout counter=0. The following all go to 0: `stall`, `load_data`, `access_err`, `bus_err`, `mem_req`, `mem_we`, `mem_addr`, `mem_wdata`, `mem_be`, and the latched funct3/addr[1:0]. Reset mid-transaction abandons it; the bus side sees `mem_req` drop immediately.
- **States**: IDLE, REQ, WAIT, DONE.
- **IDLE, no request** (rd_en=0, wr_en=0): no action, stall=0.
- **IDLE, illegal request**: rd_en&wr_en both high, misaligned (LH/LHU/SH with addr[0]=1; LW/SW with addr[1:0]!=0), or funct3 not in {000,001,010,100,101} for loads / {000,001,010} for stores.
  - access_err=1 for exactly that cycle.
  - No bus activity, stall=0, state stays IDLE.
- **IDLE, legal request**:
  - stall=1 combinationally in the same cycle.
  - Register mem_req=1, mem_we=wr_en, mem_addr={addr[31:2],2'b00}, mem_be, mem_wdata, funct3, addr[1:0]; go to REQ.
- **Store lanes**:
  - SB: be=4'b0001<<addr[1:0], wdata={4{wdata[7:0]}}.
  - SH: be=4'b0011<<{addr[1],1'b0}, wdata={2{wdata[15:0]}}.
  - SW: be=4'b1111, wdata unchanged.
- **Loads**: mem_be=4'b1111, mem_wdata=0.
- **REQ**: mem_req and all mem_* outputs held stable until mem_gnt=1. stall=1.
  - On gnt: mem_req drops next cycle. A store goes to DONE; a load goes to WAIT.
  - mem_rvalid in the same cycle as gnt (zero-latency memory) is accepted and goes straight to DONE.
- **WAIT**: stall=1. On mem_rvalid, capture formatted mem_rdata into load_data, then go to DONE.
- **Load formatting**: select the byte/half by the latched addr[1:0].
  - LB/LH sign-extend; LBU/LHU zero-extend; LW passes through.
- **DONE**: stall=0 for exactly one cycle, so the pipeline advances and the request inputs now belong to the completed instruction. DONE always goes to IDLE, never restarting the access.
- **load_data hold**: load_data holds its value until the next load completes. Stores and errors do not alter it, except on timeout.
- **Timeout**: the counter resets on entering REQ and increments each cycle in REQ/WAIT.
  - When it reaches TIMEOUT-1 without completion: drop mem_req, set load_data=0 (loads only), go to DONE with bus_err=1 during the DONE cycle.
- **Stray inputs**: mem_rvalid outside WAIT/REQ is ignored, as is mem_gnt in IDLE/WAIT/DONE.
- **Latency**: minimum access is 2 stall cycles plus DONE. Example: store with gnt in the first REQ cycle gives IDLE(stall)→REQ(stall)→DONE.

Test Plan:
- **SW with same-cycle gnt**: wr_en=1, funct3=010, addr=0x104, wdata=0xDEADBEEF, gnt in REQ → mem_addr=0x104, be=1111, mem_we=1; stall high 2 cycles, low in DONE; no errors.
- **LB sign-extension with 3-cycle rvalid delay**: rd_en=1, funct3=000, addr=0x203, rdata=0x80xxxxxx, rvalid 3 cycles after gnt → load_data=0xFFFFFF80, stall high until DONE.
- **Lane replication and unsigned load**: SH at addr=0x02, wdata=0x1234ABCD → be=1100, mem_wdata=0xABCDABCD. Then LHU same addr, rdata=0xABCD0000 → load_data=0x0000ABCD.
- **Illegal requests**: LW at addr=0x101 → access_err pulse 1 cycle, mem_req never asserted, stall=0. The same happens for rd_en=wr_en=1, and for load funct3=011.
- **Timeout**: TIMEOUT=16, gnt never asserted → mem_req high 16 cycles, then drops; bus_err pulses in DONE; load_data=0; returns to IDLE.
- **Reset mid-access**: rst low during WAIT → stall, mem_req, and load_data go to 0 immediately (async). After release, a new LW at 0x0 completes normally.
